// File: rtl/otter_rf_wb_arbiter.sv
// otter_rf_wb_arbiter
//  Arbitrates the single register-file write port between the pipeline
//  writeback stage (port A, high priority) and long-latency results
//  (port B, buffered in a DEPTH-entry FIFO). Tracks in-flight long ops in a
//  32-bit pending scoreboard and reports read hazards to decode.
//  Optional feature: define OTTER_WB_STARVE_EN to enable the B-starvation
//  counter, which forces a B grant after STARVE_LIMIT lost cycles.
module otter_rf_wb_arbiter #(
    parameter int DEPTH = 2
`ifdef OTTER_WB_STARVE_EN
    , parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       stall_in,
    input  logic                       a_valid,
    input  logic [4:0]                 a_rd,
    input  logic [31:0]                a_data,
    output logic                       a_ready,
    input  logic                       b_valid,
    input  logic [4:0]                 b_rd,
    input  logic [31:0]                b_data,
    output logic                       b_ready,
    input  logic                       alloc_valid,
    input  logic [4:0]                 alloc_rd,
    input  logic [4:0]                 chk_rs1,
    input  logic [4:0]                 chk_rs2,
    output logic                       hz1,
    output logic                       hz2,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [31:0]                pend_vec
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [4:0]    rd_mem_r   [DEPTH];
    logic [31:0]   data_mem_r [DEPTH];
    logic [PW-1:0] wptr_r;
    logic [PW-1:0] rptr_r;
    logic [CW-1:0] count_r;
    logic [31:0]   pend_r;
    logic [31:0]   pend_next_s;

    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          push_s;
    logic          pop_s;
    logic          grant_a_s;
    logic          grant_b_s;
    logic          forced_b_s;
    logic [4:0]    head_rd_s;
    logic [31:0]   head_data_s;

    assign fifo_empty_s = (count_r == {CW{1'b0}});
    assign fifo_full_s  = (count_r == FULL_CNT);
    assign head_rd_s    = rd_mem_r[rptr_r];
    assign head_data_s  = data_mem_r[rptr_r];
    // b_ready reflects the occupancy before any pop this cycle, so a full
    // FIFO never accepts even while draining.
    assign push_s       = b_valid && b_ready;
    assign pop_s        = grant_b_s;

`ifdef OTTER_WB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt_r;

    assign forced_b_s = (starve_cnt_r == STARVE_MAX) && !fifo_empty_s;

    // Count cycles the waiting B head loses to A; any pop restarts the count.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (pop_s) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (grant_a_s && !fifo_empty_s && (starve_cnt_r != STARVE_MAX)) begin
            starve_cnt_r <= starve_cnt_r + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    assign forced_b_s = 1'b0;
`endif

    // Grant selection: stall blocks everything, A wins unless B is forced.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (!reset_n || stall_in) begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else if (a_valid && !forced_b_s) begin
            grant_a_s = 1'b1;
        end else if (!fifo_empty_s) begin
            grant_b_s = 1'b1;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Register-file port and handshake outputs follow the granted source.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        a_ready  = 1'b0;
        if (grant_a_s) begin
            rf_we    = (a_rd != 5'd0);
            rf_waddr = a_rd;
            rf_wdata = a_data;
            a_ready  = 1'b1;
        end else if (grant_b_s) begin
            rf_we    = (head_rd_s != 5'd0);
            rf_waddr = head_rd_s;
            rf_wdata = head_data_s;
        end else begin
            rf_we    = 1'b0;
        end
    end

    assign b_ready    = reset_n && !fifo_full_s;
    assign fifo_count = count_r;
    assign pend_vec   = pend_r;
    assign hz1        = reset_n && pend_r[chk_rs1] && (chk_rs1 != 5'd0);
    assign hz2        = reset_n && pend_r[chk_rs2] && (chk_rs2 != 5'd0);

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_r[i]   <= 5'd0;
                data_mem_r[i] <= 32'd0;
            end
        end else begin
            if (push_s) begin
                rd_mem_r[wptr_r]   <= b_rd;
                data_mem_r[wptr_r] <= b_data;
                wptr_r             <= wptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rptr_r <= rptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Scoreboard update: B-head writes clear, allocations set (set wins).
    always_comb begin
        pend_next_s = pend_r;
        if (grant_b_s && (head_rd_s != 5'd0)) begin
            pend_next_s[head_rd_s] = 1'b0;
        end else begin
            pend_next_s = pend_r;
        end
        if (alloc_valid && (alloc_rd != 5'd0)) begin
            pend_next_s[alloc_rd] = 1'b1;
        end else begin
            pend_next_s[0] = pend_next_s[0];
        end
    end

    // Scoreboard register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_r <= 32'd0;
        end else begin
            pend_r <= pend_next_s;
        end
    end

endmodule

// File: tb/tb_otter_rf_wb_arbiter.sv
// Directed testbench for otter_rf_wb_arbiter. Inputs change 1 time unit
// after posedge; outputs are checked 1 time unit later, mid-cycle.
module tb_otter_rf_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall_in = 1'b0;
    logic        a_valid = 1'b0;
    logic [4:0]  a_rd = 5'd0;
    logic [31:0] a_data = 32'd0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [4:0]  b_rd = 5'd0;
    logic [31:0] b_data = 32'd0;
    logic        b_ready;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_rd = 5'd0;
    logic [4:0]  chk_rs1 = 5'd0;
    logic [4:0]  chk_rs2 = 5'd0;
    logic        hz1;
    logic        hz2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  fifo_count;
    logic [31:0] pend_vec;

    int tests_run = 0;
    int tests_failed = 0;

    otter_rf_wb_arbiter dut (
        .clock(clock), .reset_n(reset_n), .stall_in(stall_in),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .hz1(hz1), .hz2(hz2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fifo_count(fifo_count), .pend_vec(pend_vec)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2;
        tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL rst_we: got %0b want 0", rf_we); end
        tests_run++; if (fifo_count !== 2'd0) begin tests_failed++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        tests_run++; if (pend_vec !== 32'd0) begin tests_failed++; $display("FAIL rst_pend: got %0h want 0", pend_vec); end
        cyc(); cyc();
        reset_n = 1'b1;
        #1;
        tests_run++; if (b_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_bready: got %0b want 1", b_ready); end
        tests_run++; if (a_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_aready: got %0b want 0", a_ready); end
    endtask

    task automatic test_a_write();
        cyc();
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'hDEAD;
        #1;
        tests_run++; if (rf_we !== 1'b1) begin tests_failed++; $display("FAIL a_we: got %0b want 1", rf_we); end
        tests_run++; if (rf_waddr !== 5'd3) begin tests_failed++; $display("FAIL a_waddr: got %0d want 3", rf_waddr); end
        tests_run++; if (rf_wdata !== 32'hDEAD) begin tests_failed++; $display("FAIL a_wdata: got %0h want dead", rf_wdata); end
        tests_run++; if (a_ready !== 1'b1) begin tests_failed++; $display("FAIL a_ready: got %0b want 1", a_ready); end
        cyc();
        a_rd = 5'd0; a_data = 32'h1234;
        #1;
        tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL a_rd0_we: got %0b want 0", rf_we); end
        tests_run++; if (a_ready !== 1'b1) begin tests_failed++; $display("FAIL a_rd0_ready: got %0b want 1", a_ready); end
        cyc();
        a_valid = 1'b0;
        #1;
        tests_run++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin tests_failed++; $display("FAIL idle_port: got we=%0b addr=%0d data=%0h want 0/0/0", rf_we, rf_waddr, rf_wdata); end
        tests_run++; if (pend_vec !== 32'd0) begin tests_failed++; $display("FAIL a_no_pend: got %0h want 0", pend_vec); end
    endtask

    task automatic test_scoreboard();
        cyc();
        alloc_valid = 1'b1; alloc_rd = 5'd7; chk_rs1 = 5'd7; a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h2;
        #1;
        tests_run++; if (hz1 !== 1'b0) begin tests_failed++; $display("FAIL sb_hz1_pre: got %0b want 0", hz1); end
        cyc();
        alloc_valid = 1'b0; b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h55; chk_rs2 = 5'd7;
        #1;
        tests_run++; if (hz1 !== 1'b1) begin tests_failed++; $display("FAIL sb_hz1_set: got %0b want 1", hz1); end
        tests_run++; if (hz2 !== 1'b1) begin tests_failed++; $display("FAIL sb_hz2_set: got %0b want 1", hz2); end
        cyc();
        b_valid = 1'b0; chk_rs2 = 5'd0;
        #1;
        tests_run++; if (hz1 !== 1'b1 || fifo_count !== 2'd1) begin tests_failed++; $display("FAIL sb_busy: got hz1=%0b count=%0d want 1/1", hz1, fifo_count); end
        tests_run++; if (rf_waddr !== 5'd2) begin tests_failed++; $display("FAIL sb_a_first: got %0d want 2", rf_waddr); end
        cyc();
        a_valid = 1'b0;
        #1;
        tests_run++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h55) begin tests_failed++; $display("FAIL sb_head: got we=%0b addr=%0d data=%0h want 1/7/55", rf_we, rf_waddr, rf_wdata); end
        tests_run++; if (hz1 !== 1'b1) begin tests_failed++; $display("FAIL sb_hz1_hold: got %0b want 1", hz1); end
        cyc();
        #1;
        tests_run++; if (hz1 !== 1'b0 || pend_vec !== 32'd0 || fifo_count !== 2'd0) begin tests_failed++; $display("FAIL sb_clear: got hz1=%0b pend=%0h count=%0d want 0/0/0", hz1, pend_vec, fifo_count); end
        chk_rs1 = 5'd0;
    endtask

    task automatic test_b_latency();
        cyc();
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h44; alloc_valid = 1'b1; alloc_rd = 5'd4;
        #1;
        tests_run++; if (rf_we !== 1'b0) begin tests_failed++; $display("FAIL b_nobypass: got %0b want 0", rf_we); end
        cyc();
        b_valid = 1'b0;
        #1;
        tests_run++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h44) begin tests_failed++; $display("FAIL b_next: got we=%0b addr=%0d data=%0h want 1/4/44", rf_we, rf_waddr, rf_wdata); end
        tests_run++; if (pend_vec !== 32'h10) begin tests_failed++; $display("FAIL b_pend4: got %0h want 10", pend_vec); end
        cyc();
        alloc_rd = 5'd0; b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h45;
        #1;
        tests_run++; if (pend_vec !== 32'h10) begin tests_failed++; $display("FAIL b_setwins: got %0h want 10", pend_vec); end
        cyc();
        alloc_valid = 1'b0; b_rd = 5'd0; b_data = 32'h77;
        #1;
        tests_run++; if (pend_vec !== 32'h10 || rf_waddr !== 5'd4 || rf_wdata !== 32'h45) begin tests_failed++; $display("FAIL b_alloc0: got pend=%0h addr=%0d data=%0h want 10/4/45", pend_vec, rf_waddr, rf_wdata); end
        cyc();
        b_valid = 1'b0;
        #1;
        tests_run++; if (pend_vec !== 32'd0) begin tests_failed++; $display("FAIL b_clear4: got %0h want 0", pend_vec); end
        tests_run++; if (rf_we !== 1'b0 || fifo_count !== 2'd1) begin tests_failed++; $display("FAIL b_rd0: got we=%0b count=%0d want 0/1", rf_we, fifo_count); end
        cyc();
        #1;
        tests_run++; if (fifo_count !== 2'd0) begin tests_failed++; $display("FAIL b_rd0_pop: got %0d want 0", fifo_count); end
    endtask

    task automatic test_stall();
        cyc();
        stall_in = 1'b1; a_valid = 1'b1; a_rd = 5'd10; a_data = 32'hA0;
        b_valid = 1'b1; b_rd = 5'd11; b_data = 32'hB0;
        #1;
        tests_run++; if (rf_we !== 1'b0 || a_ready !== 1'b0) begin tests_failed++; $display("FAIL st_c1: got we=%0b ar=%0b want 0/0", rf_we, a_ready); end
        cyc();
        b_valid = 1'b0;
        #1;
        tests_run++; if (rf_we !== 1'b0 || a_ready !== 1'b0 || fifo_count !== 2'd1) begin tests_failed++; $display("FAIL st_c2: got we=%0b ar=%0b count=%0d want 0/0/1", rf_we, a_ready, fifo_count); end
        cyc();
        stall_in = 1'b0;
        #1;
        tests_run++; if (fifo_count !== 2'd1) begin tests_failed++; $display("FAIL st_hold: got %0d want 1", fifo_count); end
        tests_run++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || a_ready !== 1'b1) begin tests_failed++; $display("FAIL st_afirst: got we=%0b addr=%0d ar=%0b want 1/10/1", rf_we, rf_waddr, a_ready); end
        cyc();
        a_valid = 1'b0;
        #1;
        tests_run++; if (rf_waddr !== 5'd11 || rf_wdata !== 32'hB0) begin tests_failed++; $display("FAIL st_bnext: got addr=%0d data=%0h want 11/b0", rf_waddr, rf_wdata); end
        cyc();
    endtask

    task automatic test_full();
        cyc();
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h1;
        b_valid = 1'b1; b_rd = 5'd12; b_data = 32'hC;
        cyc();
        b_rd = 5'd13; b_data = 32'hD;
        #1;
        tests_run++; if (fifo_count !== 2'd1 || b_ready !== 1'b1) begin tests_failed++; $display("FAIL fl_one: got count=%0d br=%0b want 1/1", fifo_count, b_ready); end
        cyc();
        b_rd = 5'd14; b_data = 32'hE;
        #1;
        tests_run++; if (b_ready !== 1'b0 || fifo_count !== 2'd2) begin tests_failed++; $display("FAIL fl_full: got br=%0b count=%0d want 0/2", b_ready, fifo_count); end
        cyc();
        a_valid = 1'b0;
        #1;
        tests_run++; if (fifo_count !== 2'd2 || b_ready !== 1'b0) begin tests_failed++; $display("FAIL fl_nopush: got count=%0d br=%0b want 2/0", fifo_count, b_ready); end
        tests_run++; if (rf_waddr !== 5'd12) begin tests_failed++; $display("FAIL fl_pop1: got %0d want 12", rf_waddr); end
        cyc();
        b_rd = 5'd15; b_data = 32'hF;
        #1;
        tests_run++; if (rf_waddr !== 5'd13 || b_ready !== 1'b1) begin tests_failed++; $display("FAIL fl_pushpop: got addr=%0d br=%0b want 13/1", rf_waddr, b_ready); end
        cyc();
        b_valid = 1'b0;
        #1;
        tests_run++; if (fifo_count !== 2'd1 || rf_waddr !== 5'd15 || rf_wdata !== 32'hF) begin tests_failed++; $display("FAIL fl_order: got count=%0d addr=%0d data=%0h want 1/15/f", fifo_count, rf_waddr, rf_wdata); end
        cyc();
        #1;
        tests_run++; if (fifo_count !== 2'd0) begin tests_failed++; $display("FAIL fl_drain: got %0d want 0", fifo_count); end
    endtask

    task automatic test_starve();
        cyc();
        a_valid = 1'b1; a_rd = 5'd20; a_data = 32'h20;
        b_valid = 1'b1; b_rd = 5'd21; b_data = 32'h21;
        cyc();
        b_valid = 1'b0;
`ifdef OTTER_WB_STARVE_EN
        for (int i = 1; i <= 6; i++) begin
            #1;
            if (i == 5) begin
                tests_run++; if (a_ready !== 1'b0 || rf_waddr !== 5'd21) begin tests_failed++; $display("FAIL sv_forced: got ar=%0b addr=%0d want 0/21", a_ready, rf_waddr); end
            end else begin
                tests_run++; if (a_ready !== 1'b1 || rf_waddr !== 5'd20) begin tests_failed++; $display("FAIL sv_a%0d: got ar=%0b addr=%0d want 1/20", i, a_ready, rf_waddr); end
            end
            cyc();
        end
`else
        for (int i = 1; i <= 6; i++) begin
            #1;
            tests_run++; if (a_ready !== 1'b1 || rf_waddr !== 5'd20 || fifo_count !== 2'd1) begin tests_failed++; $display("FAIL pr_a%0d: got ar=%0b addr=%0d count=%0d want 1/20/1", i, a_ready, rf_waddr, fifo_count); end
            cyc();
        end
        a_valid = 1'b0;
        #1;
        tests_run++; if (rf_waddr !== 5'd21 || rf_we !== 1'b1) begin tests_failed++; $display("FAIL pr_bidle: got addr=%0d we=%0b want 21/1", rf_waddr, rf_we); end
        cyc();
`endif
        a_valid = 1'b0;
        cyc();
    endtask

    task automatic test_reset_midrun();
        cyc();
        alloc_valid = 1'b1; alloc_rd = 5'd5; a_valid = 1'b1; a_rd = 5'd1;
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h1;
        cyc();
        alloc_valid = 1'b0;
        cyc();
        b_valid = 1'b0;
        #1;
        tests_run++; if (fifo_count !== 2'd2 || pend_vec !== 32'h20) begin tests_failed++; $display("FAIL mr_setup: got count=%0d pend=%0h want 2/20", fifo_count, pend_vec); end
        reset_n = 1'b0;
        #1;
        tests_run++; if (fifo_count !== 2'd0 || pend_vec !== 32'd0 || rf_we !== 1'b0) begin tests_failed++; $display("FAIL mr_reset: got count=%0d pend=%0h we=%0b want 0/0/0", fifo_count, pend_vec, rf_we); end
        a_valid = 1'b0;
        cyc();
        reset_n = 1'b1;
        #1;
        tests_run++; if (b_ready !== 1'b1 || fifo_count !== 2'd0) begin tests_failed++; $display("FAIL mr_release: got br=%0b count=%0d want 1/0", b_ready, fifo_count); end
    endtask

    initial begin
        test_reset();
        test_a_write();
        test_scoreboard();
        test_b_latency();
        test_stall();
        test_full();
        test_starve();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
